// File: rtl/seq_stage_controller.sv
// Y86-64 SEQ multi-cycle sequencer: steps one instruction per pass
// F/D/E/M/W/PCUPD. Optional perf counters under SEQ_PERF_CNT_EN.
module seq_stage_controller #(
  parameter logic [63:0] RESET_PC     = 64'd0,
  parameter int unsigned MEM_WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_ready,
  input  logic        dmem_error,
  input  logic [3:0]  Ins_Code,
  input  logic        Cnd,
  input  logic [63:0] Val_C,
  input  logic [63:0] Val_P,
  input  logic [63:0] Val_M,
  input  logic        mem_invalid_check,
  input  logic        instruction_invalid_check,
  input  logic        func_invalid_check,
  output logic [63:0] PC_adress,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        memory_en,
  output logic        writeback_en,
  output logic        pc_update_en,
  output logic [1:0]  Stat,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
`endif
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT
  } state_t;

  localparam logic [1:0] ST_AOK = 2'd0;
  localparam logic [1:0] ST_HLT = 2'd1;
  localparam logic [1:0] ST_ADR = 2'd2;
  localparam logic [1:0] ST_INS = 2'd3;

  localparam logic [5:0] EN_F = 6'b000001;
  localparam logic [5:0] EN_D = 6'b000010;
  localparam logic [5:0] EN_E = 6'b000100;
  localparam logic [5:0] EN_M = 6'b001000;
  localparam logic [5:0] EN_W = 6'b010000;
  localparam logic [5:0] EN_P = 6'b100000;

  localparam logic [7:0] WAIT_LAST =
    8'(MEM_WAIT_MAX - 1);

  state_t      state;
  logic [5:0]  en;
  logic [7:0]  wait_cnt;
  logic [63:0] next_pc;

  assign fetch_en     = en[0];
  assign decode_en    = en[1];
  assign execute_en   = en[2];
  assign memory_en    = en[3];
  assign writeback_en = en[4];
  assign pc_update_en = en[5];

  // Next-PC select for the PC-update stage
  always_comb begin
    next_pc = Val_P;
    unique case (1'b1)
      (Ins_Code == 4'h7) && Cnd: next_pc = Val_C;
      (Ins_Code == 4'h8):        next_pc = Val_C;
      (Ins_Code == 4'h9):        next_pc = Val_M;
      default:                   next_pc = Val_P;
    endcase
  end

  // Stage sequencer with registered enables, PC and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      PC_adress <= RESET_PC;
      Stat      <= ST_AOK;
      halted    <= 1'b0;
      en        <= '0;
      wait_cnt  <= '0;
    end else begin
      en <= '0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            en    <= EN_F;
          end
        end
        S_FETCH: begin
          if (mem_invalid_check) begin
            state  <= S_HALT;
            Stat   <= ST_ADR;
            halted <= 1'b1;
          end else if (instruction_invalid_check ||
                       func_invalid_check) begin
            state  <= S_HALT;
            Stat   <= ST_INS;
            halted <= 1'b1;
          end else if (Ins_Code == 4'h0) begin
            state  <= S_HALT;
            Stat   <= ST_HLT;
            halted <= 1'b1;
          end else begin
            state <= S_DECODE;
            en    <= EN_D;
          end
        end
        S_DECODE: begin
          state <= S_EXECUTE;
          en    <= EN_E;
        end
        S_EXECUTE: begin
          state    <= S_MEMORY;
          en       <= EN_M;
          wait_cnt <= '0;
        end
        S_MEMORY: begin
          if (mem_ready) begin
            if (dmem_error) begin
              state  <= S_HALT;
              Stat   <= ST_ADR;
              halted <= 1'b1;
            end else begin
              state <= S_WRITEBACK;
              en    <= EN_W;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state  <= S_HALT;
            Stat   <= ST_ADR;
            halted <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            en       <= EN_M;
          end
        end
        S_WRITEBACK: begin
          state <= S_PCUPD;
          en    <= EN_P;
        end
        S_PCUPD: begin
          PC_adress <= next_pc;
          state     <= S_FETCH;
          en        <= EN_F;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Saturating busy-cycle and retired-instruction counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state != S_IDLE && state != S_HALT &&
          cycle_count != 32'hFFFF_FFFF)
        cycle_count <= cycle_count + 32'd1;
      if (state == S_PCUPD &&
          instr_count != 32'hFFFF_FFFF)
        instr_count <= instr_count + 32'd1;
    end
  end
`else
  // No performance counters in this build
`endif

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench for seq_stage_controller: a program-level model
// predicts the per-cycle stage/PC/status trace, a monitor checks it.
module tb_seq_stage_controller;

  localparam logic [63:0] RPC = 64'd0;
  localparam int          MW  = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mem_ready;
  logic        dmem_error;
  logic [3:0]  Ins_Code;
  logic        Cnd;
  logic [63:0] Val_C;
  logic [63:0] Val_P;
  logic [63:0] Val_M;
  logic        mem_invalid_check;
  logic        instruction_invalid_check;
  logic        func_invalid_check;
  logic [63:0] PC_adress;
  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        memory_en;
  logic        writeback_en;
  logic        pc_update_en;
  logic [1:0]  Stat;
  logic        halted;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
`endif

  seq_stage_controller #(
    .RESET_PC(RPC),
    .MEM_WAIT_MAX(MW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mem_ready(mem_ready),
    .dmem_error(dmem_error),
    .Ins_Code(Ins_Code),
    .Cnd(Cnd),
    .Val_C(Val_C),
    .Val_P(Val_P),
    .Val_M(Val_M),
    .mem_invalid_check(mem_invalid_check),
    .instruction_invalid_check(instruction_invalid_check),
    .func_invalid_check(func_invalid_check),
    .PC_adress(PC_adress),
    .fetch_en(fetch_en),
    .decode_en(decode_en),
    .execute_en(execute_en),
    .memory_en(memory_en),
    .writeback_en(writeback_en),
    .pc_update_en(pc_update_en),
    .Stat(Stat),
`ifdef SEQ_PERF_CNT_EN
    .cycle_count(cycle_count),
    .instr_count(instr_count),
`endif
    .halted(halted)
  );

  typedef struct {
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] vc;
    logic [63:0] vp;
    logic [63:0] vm;
    logic [2:0]  flt;
    int          mw;
    logic        derr;
  } instr_t;

  typedef struct {
    logic [3:0]  code;
    logic [63:0] pc;
    logic [1:0]  stat;
  } exp_t;

  // trace codes: 1..6 = F,D,E,M,W,P ; 7 = halted ; 15 = not one-hot
  instr_t prog[$];
  exp_t   expq[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_on = 0;
  bit     halt_seen = 0;
  int     drv_idx = 0;
  int     cur_mw = 0;
  logic   cur_derr = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name,
                              logic [63:0] got,
                              logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endfunction

  function automatic instr_t mk(input logic [3:0] ic,
                                input logic c,
                                input logic [63:0] vc,
                                input logic [63:0] vp,
                                input logic [63:0] vm,
                                input logic [2:0] flt,
                                input int mw,
                                input logic d);
    instr_t i;
    i.icode = ic; i.cnd = c; i.vc = vc; i.vp = vp; i.vm = vm;
    i.flt = flt; i.mw = mw; i.derr = d;
    return i;
  endfunction

  function automatic void push(logic [3:0] code,
                               logic [63:0] pc,
                               logic [1:0] st);
    exp_t e;
    e.code = code; e.pc = pc; e.stat = st;
    expq.push_back(e);
  endfunction

  function automatic logic [63:0] ref_next(instr_t i);
    if (i.icode == 4'h7 && i.cnd) return i.vc;
    if (i.icode == 4'h8) return i.vc;
    if (i.icode == 4'h9) return i.vm;
    return i.vp;
  endfunction

  // Walk the program instruction by instruction and list every
  // cycle the DUT should show, ending at the first stop condition.
  function automatic void build_model();
    logic [63:0] pc;
    bit done;
    pc = RPC;
    done = 0;
    expq.delete();
    foreach (prog[k]) begin
      if (!done) begin
        push(4'd1, pc, 2'd0);
        if (prog[k].flt[2]) begin
          push(4'd7, pc, 2'd2); done = 1;
        end else if (prog[k].flt[1] || prog[k].flt[0]) begin
          push(4'd7, pc, 2'd3); done = 1;
        end else if (prog[k].icode == 4'h0) begin
          push(4'd7, pc, 2'd1); done = 1;
        end else begin
          push(4'd2, pc, 2'd0);
          push(4'd3, pc, 2'd0);
          if (prog[k].mw >= MW) begin
            repeat (MW) push(4'd4, pc, 2'd0);
            push(4'd7, pc, 2'd2); done = 1;
          end else begin
            repeat (prog[k].mw + 1) push(4'd4, pc, 2'd0);
            if (prog[k].derr) begin
              push(4'd7, pc, 2'd2); done = 1;
            end else begin
              push(4'd5, pc, 2'd0);
              push(4'd6, pc, 2'd0);
              pc = ref_next(prog[k]);
            end
          end
        end
      end
    end
  endfunction

  // Stimulus: presents the next instruction during FETCH and acts
  // as a data memory that answers after a per-instruction delay.
  initial begin : drv
    int mcnt;
    mcnt = 0;
    mem_ready = 1'b0;
    dmem_error = 1'b0;
    Ins_Code = 4'h1; Cnd = 1'b0;
    Val_C = '0; Val_P = '0; Val_M = '0;
    mem_invalid_check = 1'b0;
    instruction_invalid_check = 1'b0;
    func_invalid_check = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (fetch_en && drv_idx < prog.size()) begin
          Ins_Code = prog[drv_idx].icode;
          Cnd      = prog[drv_idx].cnd;
          Val_C    = prog[drv_idx].vc;
          Val_P    = prog[drv_idx].vp;
          Val_M    = prog[drv_idx].vm;
          mem_invalid_check         = prog[drv_idx].flt[2];
          instruction_invalid_check = prog[drv_idx].flt[1];
          func_invalid_check        = prog[drv_idx].flt[0];
          cur_mw   = prog[drv_idx].mw;
          cur_derr = prog[drv_idx].derr;
          drv_idx++;
        end
        if (memory_en) begin
          mem_ready  = (mcnt == cur_mw);
          dmem_error = cur_derr;
          mcnt++;
        end else begin
          mem_ready  = 1'b0;
          dmem_error = 1'b0;
          mcnt = 0;
        end
      end else begin
        mem_ready  = 1'b0;
        dmem_error = 1'b0;
        mcnt = 0;
      end
    end
  end

  // Monitor: every cycle the DUT shows a stage or first halts,
  // pop the next expected trace entry and compare.
  initial begin : mon
    int n;
    logic [3:0] code;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        n = int'(fetch_en) + int'(decode_en) + int'(execute_en) +
            int'(memory_en) + int'(writeback_en) +
            int'(pc_update_en);
        code = 4'd0;
        if (n > 1) code = 4'd15;
        else if (fetch_en) code = 4'd1;
        else if (decode_en) code = 4'd2;
        else if (execute_en) code = 4'd3;
        else if (memory_en) code = 4'd4;
        else if (writeback_en) code = 4'd5;
        else if (pc_update_en) code = 4'd6;
        else if (halted) code = 4'd7;
        if (n > 0 || (halted && !halt_seen)) begin
          if (halted) halt_seen = 1;
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected stage %0d pc %0h", code,
                     PC_adress);
          end else begin
            e = expq.pop_front();
            chk("stage", 64'(code), 64'(e.code));
            chk("pc", PC_adress, e.pc);
            chk("stat", 64'(Stat), 64'(e.stat));
          end
        end
      end
    end
  end

  task automatic do_reset();
    mon_on = 0;
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rst_pc", PC_adress, RPC);
    chk("rst_stat", 64'(Stat), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_en", 64'({fetch_en, decode_en, execute_en,
                       memory_en, writeback_en, pc_update_en}),
        64'd0);
`ifdef SEQ_PERF_CNT_EN
    chk("rst_cyc", 64'(cycle_count), 64'd0);
    chk("rst_ins", 64'(instr_count), 64'd0);
`endif
    rst_n = 1'b1;
    drv_idx = 0;
    halt_seen = 0;
    mon_on = 1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_prog();
    int n;
    build_model();
    do_reset();
    n = 0;
    while (!halted && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!halted) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout halted %0d want 1", halted);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drained", 64'(expq.size()), 64'd0);
    chk("halt_held", 64'(halted), 64'd1);
    mon_on = 0;
  endtask

  initial begin : main
    int n;
    int len;
    int r;
    instr_t it;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);

    // nop then halt
    prog = '{mk(4'h1, 0, 0, 64'd1, 0, 3'b000, 0, 0),
             mk(4'h0, 0, 0, 0, 0, 3'b000, 0, 0)};
    run_prog();
`ifdef SEQ_PERF_CNT_EN
    chk("perf_ins", 64'(instr_count), 64'd1);
    chk("perf_cyc", 64'(cycle_count), 64'd7);
`endif
    // taken / not-taken jump at PC 8
    prog = '{mk(4'h1, 0, 0, 64'd8, 0, 3'b000, 0, 0),
             mk(4'h7, 1, 64'd32, 64'd17, 0, 3'b000, 0, 0),
             mk(4'h0, 0, 0, 0, 0, 3'b000, 0, 0)};
    run_prog();
    prog[1].cnd = 1'b0;
    run_prog();
    // call then ret
    prog = '{mk(4'h8, 0, 64'd64, 64'd9, 0, 3'b000, 0, 0),
             mk(4'h9, 0, 0, 64'd70, 64'd24, 3'b000, 0, 0),
             mk(4'h0, 0, 0, 0, 0, 3'b000, 0, 0)};
    run_prog();
    // fetch address fault outranks illegal icode
    prog = '{mk(4'h3, 0, 0, 0, 0, 3'b110, 0, 0)};
    run_prog();
    // illegal ifun alone
    prog = '{mk(4'h3, 0, 0, 0, 0, 3'b001, 0, 0)};
    run_prog();
    // memory timeout, late ready, ready on last wait cycle
    prog = '{mk(4'h5, 0, 0, 64'd5, 0, 3'b000, 8, 0)};
    run_prog();
    prog = '{mk(4'h5, 0, 0, 64'd5, 0, 3'b000, 3, 0),
             mk(4'h0, 0, 0, 0, 0, 3'b000, 0, 0)};
    run_prog();
    prog[0].mw = 7;
    run_prog();
    // data memory error
    prog = '{mk(4'h5, 0, 0, 64'd5, 0, 3'b000, 1, 1)};
    run_prog();

    // asynchronous reset in EXECUTE of the instruction at PC 64
    prog = '{mk(4'h8, 0, 64'd64, 64'd9, 0, 3'b000, 0, 0),
             mk(4'h1, 0, 0, 64'd65, 0, 3'b000, 0, 0),
             mk(4'h0, 0, 0, 0, 0, 3'b000, 0, 0)};
    build_model();
    do_reset();
    n = 0;
    while (!(execute_en && PC_adress == 64'd64) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_exec", 64'(execute_en), 64'd1);
    mon_on = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 64'({fetch_en, decode_en, execute_en,
                        memory_en, writeback_en, pc_update_en}),
        64'd0);
    chk("arst_pc", PC_adress, RPC);
    chk("arst_stat", 64'(Stat), 64'd0);
    chk("arst_halted", 64'(halted), 64'd0);
    expq.delete();
    @(posedge clk); #1;

    // random programs, always terminated by a halt
    for (int p = 0; p < 30; p++) begin
      prog.delete();
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        it.icode = 4'($urandom_range(1, 11));
        it.cnd   = 1'($urandom_range(0, 1));
        it.vc    = {$urandom(), $urandom()};
        it.vp    = {$urandom(), $urandom()};
        it.vm    = {$urandom(), $urandom()};
        r = $urandom_range(0, 24);
        it.flt = (r == 0) ? 3'b100 : (r == 1) ? 3'b010 :
                 (r == 2) ? 3'b001 : (r == 3) ? 3'b101 : 3'b000;
        it.mw = ($urandom_range(0, 7) == 0) ?
                $urandom_range(6, 10) : $urandom_range(0, 3);
        it.derr = ($urandom_range(0, 14) == 0);
        prog.push_back(it);
      end
      prog.push_back(mk(4'h0, 0, 0, 0, 0, 3'b000, 0, 0));
      run_prog();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
